// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - age-ordered collapsing issue queue with wakeup capture and registered issue port
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 64
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [31:0]                  disp_pc,
    input  logic [TAG_W-1:0]             disp_srcA_tag,
    input  logic [TAG_W-1:0]             disp_srcB_tag,
    input  logic                         disp_srcA_rdy,
    input  logic                         disp_srcB_rdy,
    input  logic [31:0]                  disp_srcA_val,
    input  logic [31:0]                  disp_srcB_val,
    input  logic [TAG_W-1:0]             disp_dest_map,
    input  logic                         disp_regwr,
    input  logic [PAYLOAD_W-1:0]         disp_payload,
    input  logic                         broadcast_flag,
    input  logic [TAG_W-1:0]             broadcast_map,
    input  logic [31:0]                  broadcast_val,
    input  logic                         flush,
    output logic                         issue_valid,
    output logic [31:0]                  issue_pc,
    output logic [31:0]                  issue_opA,
    output logic [31:0]                  issue_opB,
    output logic [TAG_W-1:0]             issue_RegWr_map,
    output logic                         issue_RegWr_flag,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef struct packed {
        logic [31:0]          pc;
        logic [TAG_W-1:0]     a_tag;
        logic                 a_rdy;
        logic [31:0]          a_val;
        logic [TAG_W-1:0]     b_tag;
        logic                 b_rdy;
        logic [31:0]          b_val;
        logic [TAG_W-1:0]     dest;
        logic                 regwr;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t                r_q [DEPTH];
    entry_t                w_q_nxt [DEPTH];
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [CNT_W-1:0]      w_sel;
    logic [CNT_W-1:0]      w_disp_idx;
    logic                  w_sel_found;
    logic                  w_disp;
    entry_t                w_sel_entry;
    entry_t                w_disp_entry;

    logic                  r_issue_valid;
    logic [31:0]           r_issue_pc;
    logic [31:0]           r_issue_opA;
    logic [31:0]           r_issue_opB;
    logic [TAG_W-1:0]      r_issue_map;
    logic                  r_issue_flag;
    logic [PAYLOAD_W-1:0]  r_issue_payload;

    // Capture a broadcast value into any still-waiting operand slot whose tag matches.
    function automatic entry_t wake(input entry_t e, input logic f,
                                    input logic [TAG_W-1:0] m, input logic [31:0] v);
        entry_t o;
        o = e;
        if (f && !e.a_rdy && (e.a_tag == m)) begin
            o.a_rdy = 1'b1;
            o.a_val = v;
        end
        if (f && !e.b_rdy && (e.b_tag == m)) begin
            o.b_rdy = 1'b1;
            o.b_val = v;
        end
        return o;
    endfunction

    // Dispatch acceptance uses only the registered occupancy; an issue this cycle never frees a slot early.
    assign disp_ready = (r_count < FULL_C);
    assign w_disp     = disp_valid && disp_ready && !flush;
    assign count      = r_count;

    assign issue_valid      = r_issue_valid;
    assign issue_pc         = r_issue_pc;
    assign issue_opA        = r_issue_opA;
    assign issue_opB        = r_issue_opB;
    assign issue_RegWr_map  = r_issue_map;
    assign issue_RegWr_flag = r_issue_flag;
    assign issue_payload    = r_issue_payload;

    // Oldest-first select over registered ready bits (scan high to low so the lowest index wins).
    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = '0;
        w_sel_entry = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if ((CNT_W'(i) < r_count) && r_q[i].a_rdy && r_q[i].b_rdy) begin
                w_sel_found = 1'b1;
                w_sel       = CNT_W'(i);
                w_sel_entry = r_q[i];
            end
        end
    end

    // Next queue image: collapse above the issued slot, apply wakeup, then append the dispatch at the tail.
    always_comb begin
        w_disp_entry         = '0;
        w_disp_entry.pc      = disp_pc;
        w_disp_entry.a_tag   = disp_srcA_tag;
        w_disp_entry.a_rdy   = disp_srcA_rdy;
        w_disp_entry.a_val   = disp_srcA_val;
        w_disp_entry.b_tag   = disp_srcB_tag;
        w_disp_entry.b_rdy   = disp_srcB_rdy;
        w_disp_entry.b_val   = disp_srcB_val;
        w_disp_entry.dest    = disp_dest_map;
        w_disp_entry.regwr   = disp_regwr;
        w_disp_entry.payload = disp_payload;
        w_disp_entry         = wake(w_disp_entry, broadcast_flag, broadcast_map, broadcast_val);

        w_disp_idx = w_sel_found ? (r_count - ONE_C) : r_count;

        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = (i < DEPTH-1) ? (i + 1) : i;
            if (w_sel_found && (CNT_W'(i) >= w_sel)) begin
                w_q_nxt[i] = wake(r_q[src], broadcast_flag, broadcast_map, broadcast_val);
            end else begin
                w_q_nxt[i] = wake(r_q[i], broadcast_flag, broadcast_map, broadcast_val);
            end
            if (w_disp && (CNT_W'(i) == w_disp_idx)) begin
                w_q_nxt[i] = w_disp_entry;
            end
        end

        w_count_nxt = r_count;
        if (w_sel_found) begin
            w_count_nxt = w_count_nxt - ONE_C;
        end
        if (w_disp) begin
            w_count_nxt = w_count_nxt + ONE_C;
        end
    end

    // Queue storage and occupancy; flush only clears occupancy since slots past count are dead.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_q_nxt[i];
            end
        end
    end

    // Issue port register; bubbles are fully zeroed so downstream sees pc==0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_issue_valid   <= 1'b0;
            r_issue_pc      <= '0;
            r_issue_opA     <= '0;
            r_issue_opB     <= '0;
            r_issue_map     <= '0;
            r_issue_flag    <= 1'b0;
            r_issue_payload <= '0;
        end else if (!flush && w_sel_found) begin
            r_issue_valid   <= 1'b1;
            r_issue_pc      <= w_sel_entry.pc;
            r_issue_opA     <= w_sel_entry.a_val;
            r_issue_opB     <= w_sel_entry.b_val;
            r_issue_map     <= w_sel_entry.dest;
            r_issue_flag    <= w_sel_entry.regwr;
            r_issue_payload <= w_sel_entry.payload;
        end else begin
            r_issue_valid   <= 1'b0;
            r_issue_pc      <= '0;
            r_issue_opA     <= '0;
            r_issue_opB     <= '0;
            r_issue_map     <= '0;
            r_issue_flag    <= 1'b0;
            r_issue_payload <= '0;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed table-driven bench for issue_queue
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int PW    = 64;
    localparam int CW    = $clog2(DEPTH+1);

    logic             CLK, RESET;
    logic             disp_valid, disp_ready;
    logic [31:0]      disp_pc;
    logic [TAG_W-1:0] disp_srcA_tag, disp_srcB_tag;
    logic             disp_srcA_rdy, disp_srcB_rdy;
    logic [31:0]      disp_srcA_val, disp_srcB_val;
    logic [TAG_W-1:0] disp_dest_map;
    logic             disp_regwr;
    logic [PW-1:0]    disp_payload;
    logic             broadcast_flag;
    logic [TAG_W-1:0] broadcast_map;
    logic [31:0]      broadcast_val;
    logic             flush;
    logic             issue_valid;
    logic [31:0]      issue_pc, issue_opA, issue_opB;
    logic [TAG_W-1:0] issue_RegWr_map;
    logic             issue_RegWr_flag;
    logic [PW-1:0]    issue_payload;
    logic [CW-1:0]    count;

    int n_total = 0;
    int n_pass  = 0;

    issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (
        .CLK(CLK), .RESET(RESET),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
        .disp_srcA_tag(disp_srcA_tag), .disp_srcB_tag(disp_srcB_tag),
        .disp_srcA_rdy(disp_srcA_rdy), .disp_srcB_rdy(disp_srcB_rdy),
        .disp_srcA_val(disp_srcA_val), .disp_srcB_val(disp_srcB_val),
        .disp_dest_map(disp_dest_map), .disp_regwr(disp_regwr), .disp_payload(disp_payload),
        .broadcast_flag(broadcast_flag), .broadcast_map(broadcast_map), .broadcast_val(broadcast_val),
        .flush(flush),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_opA(issue_opA), .issue_opB(issue_opB),
        .issue_RegWr_map(issue_RegWr_map), .issue_RegWr_flag(issue_RegWr_flag),
        .issue_payload(issue_payload), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        dv;
        logic [31:0] pc;
        logic [31:0] at;
        logic        ar;
        logic [31:0] av;
        logic [31:0] bt;
        logic        br;
        logic [31:0] bv;
        logic        bf;
        logic [31:0] bm;
        logic [31:0] bval;
        logic        fl;
        logic        eiv;
        logic [31:0] epc;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ecnt;
        logic        erdy;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(logic dv, logic [31:0] pc, logic [31:0] at, logic ar, logic [31:0] av,
                                logic [31:0] bt, logic br, logic [31:0] bv,
                                logic bf, logic [31:0] bm, logic [31:0] bval, logic fl,
                                logic eiv, logic [31:0] epc, logic [31:0] ea, logic [31:0] eb,
                                logic [31:0] ecnt, logic erdy);
        vec_t v;
        v.dv = dv; v.pc = pc; v.at = at; v.ar = ar; v.av = av;
        v.bt = bt; v.br = br; v.bv = bv; v.bf = bf; v.bm = bm; v.bval = bval; v.fl = fl;
        v.eiv = eiv; v.epc = epc; v.ea = ea; v.eb = eb; v.ecnt = ecnt; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Dest map, write flag and payload are derived from pc so the issue side can be predicted from pc.
    task automatic drive(input logic dv, input logic [31:0] pc,
                         input logic [31:0] at, input logic ar, input logic [31:0] av,
                         input logic [31:0] bt, input logic br, input logic [31:0] bv,
                         input logic bf, input logic [31:0] bm, input logic [31:0] bval, input logic fl);
        disp_valid     = dv;
        disp_pc        = pc;
        disp_srcA_tag  = at[TAG_W-1:0];
        disp_srcA_rdy  = ar;
        disp_srcA_val  = av;
        disp_srcB_tag  = bt[TAG_W-1:0];
        disp_srcB_rdy  = br;
        disp_srcB_val  = bv;
        disp_dest_map  = pc[7:2];
        disp_regwr     = pc[2];
        disp_payload   = {pc, ~pc};
        broadcast_flag = bf;
        broadcast_map  = bm[TAG_W-1:0];
        broadcast_val  = bval;
        flush          = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_issue(input string nm, input logic eiv, input logic [31:0] epc,
                             input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ecnt);
        logic [TAG_W-1:0] emap;
        logic [PW-1:0]    epay;
        emap = eiv ? epc[7:2] : '0;
        epay = eiv ? {epc, ~epc} : '0;
        chk({nm, " valid"}, 96'(issue_valid), 96'(eiv));
        chk({nm, " pc"},    96'(issue_pc), 96'(epc));
        chk({nm, " opA"},   96'(issue_opA), 96'(ea));
        chk({nm, " opB"},   96'(issue_opB), 96'(eb));
        chk({nm, " map"},   96'(issue_RegWr_map), 96'(emap));
        chk({nm, " flag"},  96'(issue_RegWr_flag), 96'(eiv ? epc[2] : 1'b0));
        chk({nm, " payload"}, 96'(issue_payload), 96'(epay));
        chk({nm, " count"}, 96'(count), 96'(ecnt));
    endtask

    initial begin
        //           dv pc     at ar av  bt br bv  bf bm bval   fl  eiv epc    ea    eb      cnt rdy
        vt[0]  = mk(1, 32'h400, 0, 1, 5,  0, 1, 7,  0, 0, 0,     0,  0, 0,     0,    0,      1,  1);
        vt[1]  = mk(0, 0,       0, 0, 0,  0, 0, 0,  0, 0, 0,     0,  1, 32'h400, 5,  7,      0,  1);
        vt[2]  = mk(0, 0,       0, 0, 0,  0, 0, 0,  0, 0, 0,     0,  0, 0,     0,    0,      0,  1);
        vt[3]  = mk(1, 32'h100, 1, 1, 1,  9, 0, 0,  0, 0, 0,     0,  0, 0,     0,    0,      1,  1);
        vt[4]  = mk(1, 32'h104, 0, 1, 2,  0, 1, 3,  0, 0, 0,     0,  0, 0,     0,    0,      2,  1);
        vt[5]  = mk(0, 0,       0, 0, 0,  0, 0, 0,  1, 9, 32'hDEAD, 0, 1, 32'h104, 2, 3,     1,  1);
        vt[6]  = mk(0, 0,       0, 0, 0,  0, 0, 0,  0, 0, 0,     0,  1, 32'h100, 1, 32'hDEAD, 0, 1);
        vt[7]  = mk(1, 32'h200, 3, 0, 0,  0, 1, 4,  1, 3, 32'h11, 0, 0, 0,     0,    0,      1,  1);
        vt[8]  = mk(0, 0,       0, 0, 0,  0, 0, 0,  0, 0, 0,     0,  1, 32'h200, 32'h11, 4,  0,  1);
        vt[9]  = mk(1, 32'h300, 5, 1, 32'h55, 5, 0, 0, 1, 5, 32'h66, 0, 0, 0,   0,    0,      1,  1);
        vt[10] = mk(0, 0,       0, 0, 0,  0, 0, 0,  0, 0, 0,     0,  1, 32'h300, 32'h55, 32'h66, 0, 1);
        vt[11] = mk(1, 32'h500, 0, 1, 8,  7, 0, 0,  0, 0, 0,     0,  0, 0,     0,    0,      1,  1);
        vt[12] = mk(0, 0,       0, 0, 0,  0, 0, 0,  1, 7, 32'h77, 0, 0, 0,     0,    0,      1,  1);
        vt[13] = mk(0, 0,       0, 0, 0,  0, 0, 0,  0, 0, 0,     0,  1, 32'h500, 8, 32'h77,  0,  1);
        vt[14] = mk(1, 32'h600, 0, 1, 1,  0, 1, 2,  0, 0, 0,     0,  0, 0,     0,    0,      1,  1);
        vt[15] = mk(1, 32'h604, 0, 1, 3,  0, 1, 4,  0, 0, 0,     0,  1, 32'h600, 1,  2,      1,  1);
        vt[16] = mk(0, 0,       0, 0, 0,  0, 0, 0,  0, 0, 0,     0,  1, 32'h604, 3,  4,      0,  1);

        RESET = 1'b0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        chk_issue("reset", 0, 0, 0, 0, 0);
        RESET = 1'b1;
        #1;
        chk("reset disp_ready", 96'(disp_ready), 96'(1));

        // Table of single-cycle vectors: inputs held across one edge, outputs checked just after it.
        for (int k = 0; k < 17; k++) begin
            drive(vt[k].dv, vt[k].pc, vt[k].at, vt[k].ar, vt[k].av, vt[k].bt, vt[k].br, vt[k].bv,
                  vt[k].bf, vt[k].bm, vt[k].bval, vt[k].fl);
            tick();
            chk_issue($sformatf("vec%0d", k), vt[k].eiv, vt[k].epc, vt[k].ea, vt[k].eb, vt[k].ecnt);
            chk($sformatf("vec%0d disp_ready", k), 96'(disp_ready), 96'(vt[k].erdy));
        end

        // Full: eight entries all waiting on srcA tags 10..17.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 32'h1000 + 32'(4*k), 32'(10+k), 0, 0, 0, 1, 32'(k), 0, 0, 0, 0);
            tick();
        end
        chk("full count", 96'(count), 96'(8));
        chk("full disp_ready", 96'(disp_ready), 96'(0));
        drive(1, 32'h2000, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        tick();
        chk("drop count", 96'(count), 96'(8));
        chk("drop valid", 96'(issue_valid), 96'(0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 32'hABC, 0);
        tick();
        chk("nobypass valid", 96'(issue_valid), 96'(0));
        chk("nobypass count", 96'(count), 96'(8));
        idle();
        tick();
        chk_issue("full wake", 1, 32'h100C, 32'hABC, 3, 7);
        chk("full wake disp_ready", 96'(disp_ready), 96'(1));
        tick();
        chk_issue("full after", 0, 0, 0, 0, 7);
        drive(1, 32'h3000, 0, 1, 1, 0, 1, 1, 1, 10, 1, 1);
        tick();
        chk_issue("full flush", 0, 0, 0, 0, 0);

        // Flush with five queued entries plus simultaneous dispatch and broadcast.
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h5000 + 32'(4*k), 32'(20+k), 0, 0, 0, 1, 1, 0, 0, 0, 0);
            tick();
        end
        chk("flush5 count", 96'(count), 96'(5));
        drive(1, 32'h7000, 0, 1, 1, 0, 1, 1, 1, 20, 32'h99, 1);
        tick();
        chk_issue("flush5", 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(21+k), 32'h5, 0);
            tick();
            chk_issue($sformatf("postflush%0d", k), 0, 0, 0, 0, 0);
        end

        // Asynchronous reset mid-operation with three entries held and an issue on the port.
        drive(1, 32'h6000, 30, 0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h6004, 31, 0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 32'h6008, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0); tick();
        drive(1, 32'h600C, 32, 0, 0, 0, 1, 0, 0, 0, 0, 0); tick();
        chk_issue("pre-reset", 1, 32'h6008, 1, 2, 3);
        idle();
        #2;
        RESET = 1'b0;
        #1;
        chk_issue("async reset", 0, 0, 0, 0, 0);
        chk("async reset disp_ready", 96'(disp_ready), 96'(1));
        #1;
        RESET = 1'b1;
        drive(1, 32'h800, 0, 1, 9, 0, 1, 10, 0, 0, 0, 0);
        tick();
        chk_issue("redisp", 0, 0, 0, 0, 1);
        idle();
        tick();
        chk_issue("redisp issue", 1, 32'h800, 9, 10, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Age-ordered, collapsing issue queue directly upstream of the execute stage.
- Holds renamed instructions until both source operands are available. Captures operand values from the execute stage's result broadcast (wakeup).
- Each cycle, selects the oldest ready entry and drives the execute stage's operand/control inputs through a registered issue port.
- Flush empties the queue, discarding wrong-path work.

Parameters:
- DEPTH, 8, number of entries (power of two not required; 2..16).
- TAG_W, 6, physical register map width.
- PAYLOAD_W, 64, opaque per-instruction bits (instr, ALU control, shamt, dest reg, mem flags) passed through unmodified.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- disp_valid  input  1  dispatch request.
- disp_ready  output  1  queue can accept a dispatch this cycle.
- disp_pc  input  32  instruction PC; must be nonzero for real instructions.
- disp_srcA_tag / disp_srcB_tag  input  TAG_W each  source physical maps.
- disp_srcA_rdy / disp_srcB_rdy  input  1 each  operand value already known.
- disp_srcA_val / disp_srcB_val  input  32 each  operand values, valid when rdy=1.
- disp_dest_map  input  TAG_W  destination physical map.
- disp_regwr  input  1  instruction writes a register.
- disp_payload  input  PAYLOAD_W  pass-through bits.
- broadcast_flag  input  1  wakeup valid.
- broadcast_map  input  TAG_W  produced tag.
- broadcast_val  input  32  produced value.
- flush  input  1  discard all entries.
- issue_valid  output  1  registered; an instruction is presented.
- issue_pc  output  32  PC; 0 when issue_valid=0.
- issue_opA / issue_opB  output  32 each  operand values.
- issue_RegWr_map  output  TAG_W  destination map.
- issue_RegWr_flag  output  1  destination write flag.
- issue_payload  output  PAYLOAD_W  pass-through bits.
- count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async, RESET=0): all entries invalid; count=0; issue_valid=0. issue_pc, issue_opA, issue_opB, issue_RegWr_map, issue_RegWr_flag and issue_payload all 0. disp_ready=1 once reset is released.
- Storage: entries 0..count-1 are valid. Entry 0 is the oldest. Each entry holds pc, two {tag, rdy, val} operand slots, dest_map, regwr and payload.
- disp_ready = (count < DEPTH), computed from registered count only. A same-cycle issue does not free a slot for dispatch.
- Dispatch (disp_valid & disp_ready & !flush): the new entry is written at index count, or count-1 if an issue occurs in the same cycle.
- Wakeup: on broadcast_flag, every valid operand slot with rdy=0 and tag==broadcast_map sets rdy=1 and captures broadcast_val.
  - This also applies to the instruction being dispatched in the same cycle: matching disp tags with rdy=0 are stored as ready with broadcast_val.
  - A slot whose rdy is already 1 is never overwritten.
- Select: the lowest index i with valid & srcA.rdy & srcB.rdy, using registered rdy state.
  - An entry woken in cycle N is first eligible in cycle N+1. No same-cycle wakeup-to-select bypass.
  - Latency: dispatch with both operands ready at edge N is presented on issue_* after edge N+1.
- Issue: at the edge, the selected entry is copied to the issue_* registers with issue_valid=1. Entries above it shift down by one (collapse), preserving age order. count = count - 1 + (dispatch accepted).
- No ready entry: at the edge, issue_valid=0 and issue_pc=0. The other issue_* outputs are zeroed too, so the downstream PC!=0 qualification sees a bubble.
- The execute stage never stalls: one issue per cycle maximum, and it is always consumed.
- Flush (synchronous, highest priority): at the edge, all entries are invalidated, count=0, issue_valid=0 and issue_pc=0. A dispatch and any wakeup in the same cycle are dropped.
- Full boundary: count==DEPTH gives disp_ready=0. A disp_valid while not ready is ignored, with no state change.
- Empty boundary: count==0 with dispatch and no issue gives count=1 next cycle. The new entry is issued no earlier than the following edge.
- Wrap-around: not applicable (collapsing structure). count never exceeds DEPTH and never underflows.

Test Plan:
- Reset mid-operation: fill 3 entries, assert RESET=0 asynchronously → count=0, issue_valid=0, issue_pc=0 immediately. Re-dispatch after release works normally.
- Ready dispatch: pc=0x400, opA=5, opB=7 (both rdy) at edge 1 → after edge 2, issue_valid=1, issue_pc=0x400, issue_opA=5, issue_opB=7. count returns to 0.
- Wakeup and age order: dispatch A (pc 0x100, srcB tag 9 not ready), then B (pc 0x104, ready) → B issues first. Broadcast map=9, val=0xDEAD → A issues one cycle later with issue_opB=0xDEAD.
- Same-cycle dispatch and broadcast: dispatch srcA tag 3 not ready while broadcast map=3, val=0x11 → entry stored ready and issues with issue_opA=0x11 next edge.
- Full: DEPTH=8 unready entries → disp_ready=0 and a 9th disp_valid is dropped. One wakeup issues one entry; disp_ready=1 the cycle after count drops to 7.
- Flush: 5 entries queued, flush=1 with simultaneous disp_valid and broadcast → count=0, issue_valid=0, issue_pc=0 next cycle. No later issue from the old entries.
